sram_render_arbiter: RTL and testbench

- Single-port frame-buffer SRAM controller that shares the SRAM between three users: the VGA pixel fetch, a game-logic write port and a frame-clear engine.
- Render reads have absolute priority and fixed 2-cycle latency. The VGA timing core presents pixel coordinates two cycles before it samples the colour.
- Game writes are buffered in a small FIFO. Writes and clears drain in every cycle that is not a render read.

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_render_arbiter_if.sv | 14 +
 rtl/sram_wr_fifo.sv | 42 ++++
 rtl/sram_render_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sram_render_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and widths for the frame-buffer SRAM arbiter slice.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_WIDTH = 20;
    localparam int unsigned MAP_H_WIDTH     = 10;
    localparam int unsigned MAP_V_WIDTH     = 9;

    typedef struct packed {
        logic [SRAM_ADDR_WIDTH-1:0] addr;
        logic [15:0]                data;
    } wr_req_t;

    typedef enum logic [1:0] {SLOT_NOP, SLOT_READ, SLOT_CLEAR, SLOT_WRITE} arb_slot_e;

    typedef enum logic {S_RUN, S_CLEAR} clear_state_e;

    // RGB565 to RGB888 by replicating the top bits of each channel.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/sram_render_arbiter_if.sv
// SRAM pin bundle: the arbiter drives it as master, the SRAM device is the slave.
interface sram_render_arbiter_if;
    import sram_pkg::*;

    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [15:0]                wdata;
    logic                       we_n;
    logic                       oe_n;
    logic [15:0]                rdata;

    modport master (output addr, output wdata, output we_n, output oe_n, input rdata);
    modport slave  (input addr, input wdata, input we_n, input oe_n, output rdata);

endinterface

// File: rtl/sram_wr_fifo.sv
// Synchronous FIFO of game write requests; DEPTH must be a power of two, >= 2.
module sram_wr_fifo
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    push_i,
    input  wr_req_t data_i,
    input  logic    pop_i,
    output wr_req_t data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    wr_req_t        mem_q [DEPTH];
    logic [AW:0]    wptr_q;
    logic [AW:0]    rptr_q;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop_i)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/sram_render_arbiter.sv
// Frame-buffer SRAM arbiter: render reads > frame clear > queued game writes.
// Optional SRAM_ARB_STALL_COUNT_EN adds o_stall_cycles (FIFO stalled by read/clear).
module sram_render_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned H_SIZE        = 640,
    parameter int unsigned V_SIZE        = 480,
    parameter int unsigned WR_FIFO_DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_render_clk,
    input  logic [MAP_H_WIDTH-1:0]     i_H_render,
    input  logic [MAP_V_WIDTH-1:0]     i_V_render,
    output logic [23:0]                o_color,
    input  logic                       i_wr_valid,
    output logic                       o_wr_ready,
    input  logic [SRAM_ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [15:0]                i_wr_data,
    input  logic                       i_clear_req,
    input  logic [15:0]                i_clear_data,
    output logic                       o_clear_busy,
    output logic                       o_clear_done,
`ifdef SRAM_ARB_STALL_COUNT_EN
    output logic [31:0]                o_stall_cycles,
`endif
    sram_render_arbiter_if.master      sram
);

    localparam logic [SRAM_ADDR_WIDTH-1:0] LAST_C = SRAM_ADDR_WIDTH'(H_SIZE * V_SIZE - 1);
    localparam logic [SRAM_ADDR_WIDTH-1:0] H_STEP = SRAM_ADDR_WIDTH'(H_SIZE);

    clear_state_e               state_q, state_d;
    arb_slot_e                  slot;
    logic [SRAM_ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [15:0]                clr_data_q, clr_data_d;
    logic                       clr_last, last_q, done_q;
    logic [MAP_V_WIDTH-1:0]     v_q;
    logic [SRAM_ADDR_WIDTH-1:0] base_q, base_d, rd_addr;
    logic                       rd_slot, rd_q;
    logic [15:0]                rdata_q;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]                wdata_q, wdata_d;
    logic                       we_n_q, we_n_d, oe_n_q, oe_n_d;
    logic                       fifo_full, fifo_empty, fifo_push, fifo_pop;
    wr_req_t                    fifo_head;

    assign rd_slot = i_render_clk
                  && (i_H_render != '0) && (32'(i_H_render) <= H_SIZE)
                  && (i_V_render != '0) && (32'(i_V_render) <= V_SIZE);

    // Row base follows V as it restarts at 1 or steps by one line; no multiplier.
    always_comb begin
        base_d = base_q;
        if (i_V_render == MAP_V_WIDTH'(1))
            base_d = '0;
        else if (i_V_render == v_q + MAP_V_WIDTH'(1))
            base_d = base_q + H_STEP;
    end

    assign rd_addr = base_d + SRAM_ADDR_WIDTH'(i_H_render) - SRAM_ADDR_WIDTH'(1);

    assign fifo_push  = i_wr_valid && o_wr_ready;
    assign o_wr_ready = !fifo_full;

    sram_wr_fifo #(.DEPTH(WR_FIFO_DEPTH)) u_wr_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push_i  (fifo_push),
        .data_i  ('{addr: i_wr_addr, data: i_wr_data}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_data_d = clr_data_q;
        clr_last   = 1'b0;
        slot       = SLOT_NOP;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_n_d     = 1'b1;
        oe_n_d     = 1'b1;

        if (rd_slot)                 slot = SLOT_READ;
        else if (state_q == S_CLEAR) slot = SLOT_CLEAR;
        else if (!fifo_empty)        slot = SLOT_WRITE;

        unique case (state_q)
            S_RUN: begin
                if (i_clear_req) begin
                    state_d    = S_CLEAR;
                    clr_cnt_d  = '0;
                    clr_data_d = i_clear_data;
                end
            end
            S_CLEAR: begin
                if (slot == SLOT_CLEAR) begin
                    clr_cnt_d = clr_cnt_q + SRAM_ADDR_WIDTH'(1);
                    if (clr_cnt_q == LAST_C) begin
                        state_d  = S_RUN;
                        clr_last = 1'b1;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase

        unique case (slot)
            SLOT_READ: begin
                addr_d = rd_addr;
                oe_n_d = 1'b0;
            end
            SLOT_CLEAR: begin
                addr_d  = clr_cnt_q;
                wdata_d = clr_data_q;
                we_n_d  = 1'b0;
            end
            SLOT_WRITE: begin
                addr_d  = fifo_head.addr;
                wdata_d = fifo_head.data;
                we_n_d  = 1'b0;
            end
            default: ;
        endcase
    end

    assign fifo_pop = (slot == SLOT_WRITE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_RUN;
            clr_cnt_q  <= '0;
            clr_data_q <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            v_q        <= MAP_V_WIDTH'(1);
            base_q     <= '0;
            rd_q       <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_data_q <= clr_data_d;
            last_q     <= clr_last;
            done_q     <= last_q;
            v_q        <= i_V_render;
            base_q     <= base_d;
            rd_q       <= rd_slot;
            rdata_q    <= rd_q ? sram.rdata : '0;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
        end
    end

    // Busy covers the final clear write on the pins; done follows one cycle later.
    assign o_clear_busy = (state_q == S_CLEAR) || last_q;
    assign o_clear_done = done_q;
    assign o_color      = rgb565_to_888(rdata_q);
    assign sram.addr    = addr_q;
    assign sram.wdata   = wdata_q;
    assign sram.we_n    = we_n_q;
    assign sram.oe_n    = oe_n_q;

`ifdef SRAM_ARB_STALL_COUNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            stall_q <= '0;
        else if (!fifo_empty && (slot == SLOT_READ || slot == SLOT_CLEAR) && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end

    assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_sram_render_arbiter.sv
// Directed bench for sram_render_arbiter on a reduced 40x30 frame with an SRAM model.
module tb_sram_render_arbiter;
    import sram_pkg::*;

    localparam int unsigned HS = 40;
    localparam int unsigned VS = 30;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       render_clk;
    logic [MAP_H_WIDTH-1:0]     h_r;
    logic [MAP_V_WIDTH-1:0]     v_r;
    logic [23:0]                color;
    logic                       wr_valid, wr_ready;
    logic [SRAM_ADDR_WIDTH-1:0] wr_addr;
    logic [15:0]                wr_data;
    logic                       clear_req, clear_busy, clear_done;
    logic [15:0]                clear_data;
`ifdef SRAM_ARB_STALL_COUNT_EN
    logic [31:0]                stall_cycles;
`endif

    sram_render_arbiter_if sram_bus ();

    sram_render_arbiter #(.H_SIZE(HS), .V_SIZE(VS), .WR_FIFO_DEPTH(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_render_clk (render_clk),
        .i_H_render   (h_r),
        .i_V_render   (v_r),
        .o_color      (color),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_clear_req  (clear_req),
        .i_clear_data (clear_data),
        .o_clear_busy (clear_busy),
        .o_clear_done (clear_done),
`ifdef SRAM_ARB_STALL_COUNT_EN
        .o_stall_cycles (stall_cycles),
`endif
        .sram         (sram_bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [2048];
    logic        pl_en = 1'b0;
    logic [10:0] pl_addr;
    logic [15:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!sram_bus.we_n) mem[sram_bus.addr[10:0]] <= sram_bus.wdata;
    end
    assign sram_bus.rdata = mem[sram_bus.addr[10:0]];

    int n_assert = 0;
    int n_fail   = 0;
    int nwr, bad, busy_low, last_wr, done_n, done_at, busy_at_done;
    int rd_bad, clr_bad, clr_exp, early, done_we, done_addr, done_wdata, nxt_addr, nxt_wdata;
    int found, j;
    logic rd;
    logic [23:0] e_prev, e_cur;

    function automatic logic [23:0] exp888(input logic [15:0] p);
        logic [4:0] r5; logic [5:0] g6; logic [4:0] b5;
        r5 = p[15:11]; g6 = p[10:5]; b5 = p[4:0];
        return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

    function automatic logic [15:0] pat(input int k);
        return 16'(k * 16'h0843 + 16'h1111);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = 11'(a); pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; render_clk = 1'b0; h_r = '0; v_r = MAP_V_WIDTH'(1);
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear_req = 1'b0; clear_data = '0;
        tick();
        preload(0, 16'hF800);
        preload(5, 16'h8410);
        preload(79, 16'h07E0);
        preload(1200, 16'h1234);
        check("rst_color", 32'(color), 0);
        check("rst_ready", 32'(wr_ready), 1);
        check("rst_busy",  32'(clear_busy), 0);
        check("rst_done",  32'(clear_done), 0);
        check("rst_we_n",  32'(sram_bus.we_n), 1);
        check("rst_oe_n",  32'(sram_bus.oe_n), 1);
        check("rst_addr",  32'(sram_bus.addr), 0);
        check("rst_wdata", 32'(sram_bus.wdata), 0);
        rst_n = 1'b1;
        tick();

        // Render fetch and row addressing
        render_clk = 1'b1; h_r = 10'd1; v_r = 9'd1; tick();
        check("rd0_addr", 32'(sram_bus.addr), 0);
        check("rd0_oe_n", 32'(sram_bus.oe_n), 0);
        check("rd0_we_n", 32'(sram_bus.we_n), 1);
        h_r = 10'd6; tick();
        check("rd0_color", 32'(color), 32'hFF0000);
        check("rd5_addr", 32'(sram_bus.addr), 5);
        h_r = 10'd40; v_r = 9'd2; tick();
        check("rd5_color", 32'(color), 32'h848284);
        check("row2_addr", 32'(sram_bus.addr), 79);
        h_r = 10'd0; tick();
        check("row2_color", 32'(color), 32'h00FF00);
        check("h0_oe_n", 32'(sram_bus.oe_n), 1);
        check("h0_addr_hold", 32'(sram_bus.addr), 79);
        h_r = 10'd41; tick();
        check("h0_color", 32'(color), 0);
        check("h41_oe_n", 32'(sram_bus.oe_n), 1);
        render_clk = 1'b0; h_r = 10'd1; v_r = 9'd1; tick();
        check("h41_color", 32'(color), 0);
        check("off_oe_n", 32'(sram_bus.oe_n), 1);
        tick();
        check("off_color", 32'(color), 0);

        // Write queueing behind continuous read slots
        render_clk = 1'b1; v_r = 9'd1;
        for (int k = 0; k < 4; k++) begin
            h_r = MAP_H_WIDTH'(k + 1); wr_valid = 1'b1;
            wr_addr = SRAM_ADDR_WIDTH'(100 + k); wr_data = 16'(16'hA000 + k);
            check($sformatf("ready_push%0d", k), 32'(wr_ready), 1);
            tick();
        end
        h_r = 10'd5; wr_addr = 20'd104; wr_data = 16'hA004;
        check("ready_full", 32'(wr_ready), 0);
        tick();
        check("full_rd_we_n", 32'(sram_bus.we_n), 1);
        check("full_rd_oe_n", 32'(sram_bus.oe_n), 0);
        render_clk = 1'b0;
        check("ready_full2", 32'(wr_ready), 0);
        tick();
        check("ready_after_pop", 32'(wr_ready), 1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("drain%0d_we_n", k), 32'(sram_bus.we_n), 0);
            check($sformatf("drain%0d_addr", k), 32'(sram_bus.addr), 32'(100 + k));
            check($sformatf("drain%0d_wdata", k), 32'(sram_bus.wdata), 32'(16'hA000 + k));
            tick();
            wr_valid = 1'b0;
        end
        check("drain_nop_we_n", 32'(sram_bus.we_n), 1);
        check("drain_nop_addr", 32'(sram_bus.addr), 104);

        // Full clear with render off
        clear_data = 16'h001F; clear_req = 1'b1; tick(); clear_req = 1'b0;
        check("clr_busy_start", 32'(clear_busy), 1);
        nwr = 0; bad = 0; busy_low = 0; last_wr = -1; done_n = 0; done_at = -1; busy_at_done = -1;
        for (int n = 1; n < 1400; n++) begin
            if (!sram_bus.we_n) begin
                if (sram_bus.addr != SRAM_ADDR_WIDTH'(nwr) || sram_bus.wdata != 16'h001F) bad++;
                if (!clear_busy) busy_low++;
                if (last_wr >= 0 && n != last_wr + 1) bad++;
                last_wr = n; nwr++;
            end
            if (clear_done) begin done_n++; done_at = n; busy_at_done = int'(clear_busy); end
            tick();
            if (done_n > 0 && n >= done_at + 3) break;
        end
        check("clr_writes", 32'(nwr), HS * VS);
        check("clr_order", 32'(bad), 0);
        check("clr_busy_high", 32'(busy_low), 0);
        check("clr_done_count", 32'(done_n), 1);
        check("clr_done_timing", 32'(done_at), 32'(last_wr + 1));
        check("clr_busy_at_done", 32'(busy_at_done), 0);
        check("clr_mem_first", 32'(mem[0]), 32'h001F);
        check("clr_mem_last", 32'(mem[1199]), 32'h001F);
        check("clr_mem_beyond", 32'(mem[1200]), 32'h1234);

        // Clear interleaved with reads on row 30, two writes pending
        for (int v = 1; v <= 30; v++) begin v_r = MAP_V_WIDTH'(v); tick(); end
        for (int k = 0; k < 20; k++) preload(1160 + k, pat(k));
        e_prev = '0; rd_bad = 0; clr_bad = 0; clr_exp = 0; early = 0; done_n = 0; done_at = -1;
        done_we = -1; done_addr = -1; done_wdata = -1; nxt_addr = -1; nxt_wdata = -1;
        for (int n = 0; n < 1500; n++) begin
            clear_req = (n == 0); clear_data = 16'h7777;
            wr_valid = (n < 2); wr_addr = SRAM_ADDR_WIDTH'(1500 + n);
            wr_data = (n == 0) ? 16'hBEEF : 16'hCAFE;
            rd = (n % 2 == 1) && (n < 40);
            j = (n - 1) / 2;
            render_clk = rd; h_r = rd ? MAP_H_WIDTH'(j + 1) : 10'd1;
            e_cur = rd ? exp888(pat(j)) : 24'h0;
            tick();
            if (color !== e_prev) rd_bad++;
            if (rd && (sram_bus.oe_n !== 1'b0 || sram_bus.we_n !== 1'b1
                       || sram_bus.addr != SRAM_ADDR_WIDTH'(1160 + j))) rd_bad++;
            if (done_at >= 0 && n + 1 == done_at + 1) begin
                nxt_addr = int'(sram_bus.addr); nxt_wdata = int'(sram_bus.wdata);
            end
            if (!sram_bus.we_n) begin
                if (sram_bus.addr == 20'd1500 || sram_bus.addr == 20'd1501) begin
                    if (done_n == 0 && !clear_done) early++;
                end else begin
                    if (sram_bus.addr != SRAM_ADDR_WIDTH'(clr_exp) || sram_bus.wdata != 16'h7777) clr_bad++;
                    clr_exp++;
                end
            end
            if (clear_done) begin
                done_n++; done_at = n + 1;
                done_we = int'(sram_bus.we_n); done_addr = int'(sram_bus.addr); done_wdata = int'(sram_bus.wdata);
            end
            e_prev = e_cur;
            if (done_at >= 0 && n + 1 >= done_at + 2) break;
        end
        clear_req = 1'b0; wr_valid = 1'b0; render_clk = 1'b0;
        tick();
        check("mix_read_latency", 32'(rd_bad), 0);
        check("mix_clr_writes", 32'(clr_exp), HS * VS);
        check("mix_clr_order", 32'(clr_bad), 0);
        check("mix_fifo_early", 32'(early), 0);
        check("mix_done_count", 32'(done_n), 1);
        check("mix_done_we_n", 32'(done_we), 0);
        check("mix_done_addr", 32'(done_addr), 1500);
        check("mix_done_wdata", 32'(done_wdata), 32'hBEEF);
        check("mix_next_addr", 32'(nxt_addr), 1501);
        check("mix_next_wdata", 32'(nxt_wdata), 32'hCAFE);
        check("mix_mem_1500", 32'(mem[1500]), 32'hBEEF);
        check("mix_mem_1501", 32'(mem[1501]), 32'hCAFE);

        // Reset in the middle of a clear
        preload(1600, 16'h5A5A);
        clear_data = 16'h3333; clear_req = 1'b1; tick(); clear_req = 1'b0;
        wr_valid = 1'b1; wr_addr = 20'd1600; wr_data = 16'hDEAD; tick(); tick(); wr_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 1200; n++) begin
            if (!sram_bus.we_n && sram_bus.addr == 20'd1000) begin found = 1; break; end
            tick();
        end
        check("mid_reach_c1000", 32'(found), 1);
        rst_n = 1'b0; #1;
        check("mid_rst_addr", 32'(sram_bus.addr), 0);
        check("mid_rst_wdata", 32'(sram_bus.wdata), 0);
        check("mid_rst_we_n", 32'(sram_bus.we_n), 1);
        check("mid_rst_oe_n", 32'(sram_bus.oe_n), 1);
        check("mid_rst_busy", 32'(clear_busy), 0);
        check("mid_rst_color", 32'(color), 0);
        check("mid_rst_ready", 32'(wr_ready), 1);
        tick(); tick();
        rst_n = 1'b1;
        bad = 0; done_n = 0;
        for (int n = 0; n < 8; n++) begin
            if (!sram_bus.we_n) bad++;
            if (clear_done) done_n++;
            tick();
        end
        check("mid_no_writes", 32'(bad), 0);
        check("mid_no_done", 32'(done_n), 0);
        clear_data = 16'h0F0F; clear_req = 1'b1; tick(); clear_req = 1'b0; tick();
        check("restart_we_n", 32'(sram_bus.we_n), 0);
        check("restart_addr", 32'(sram_bus.addr), 0);
        check("restart_wdata", 32'(sram_bus.wdata), 32'h0F0F);
        check("restart_busy", 32'(clear_busy), 1);
        done_n = 0;
        for (int n = 0; n < 1400; n++) begin
            if (clear_done) begin done_n++; break; end
            tick();
        end
        check("restart_done", 32'(done_n), 1);
        check("restart_mem_1600", 32'(mem[1600]), 32'h5A5A);
        check("restart_mem_1199", 32'(mem[1199]), 32'h0F0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
